pwm_capture: RTL and testbench

Audio-path receiver that turns a 1-bit PWM/PDM stream back into BITDEPTH-bit PCM samples, one per sample period. It is the other end of the DAC link: it takes the pin-level output of the sigma-delta/PWM DAC, or an external 1-bit source, and rebuilds the sample stream. It is used for on-board loopback self-test of the synth chain and for capturing 1-bit audio input. It counts high cycles of the synchronized input over each sample_clock window and scales the count to full-scale PCM.

---
 rtl/pwm_capture_pkg.sv | 11 +
 rtl/bit_sync.sv | 25 ++
 rtl/pwm_capture.sv | 115 +++++++++++
 tb/tb_pwm_capture.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared audio-chain constants for the 1-bit capture path.
// Default PCM width, window divider and capture FSM encodings.
package pwm_capture_pkg;

    localparam int AUDIO_BITDEPTH = 14;
    localparam int AUDIO_SCLK_DIV = 8;

    localparam logic [0:0] WAIT    = 1'b0;
    localparam logic [0:0] CAPTURE = 1'b1;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Used for pwm input capture and for button inputs.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain; clear on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// 1-bit PWM/PDM to PCM receiver: counts high cycles per
// sample_clock window and scales the count to full scale.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int BITDEPTH        = AUDIO_BITDEPTH,
    parameter int SAMPLECLOCK_DIV = AUDIO_SCLK_DIV,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clock,
    input  logic                pwm_in,
    output logic [BITDEPTH-1:0] pcm,
    output logic                pcm_valid,
    output logic                window_err
);

    localparam int CW    = SAMPLECLOCK_DIV + 1;
    localparam int SHIFT = BITDEPTH - SAMPLECLOCK_DIV;
    localparam logic [CW-1:0] NOMINAL = CW'(1) << SAMPLECLOCK_DIV;
    localparam logic [CW-1:0] LEN_MAX = '1;

    logic                pwm_s;
    logic                sc_q;
    logic                sc_rise;
    logic [CW-1:0]       pwm_ext;
    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       len_q, len_d;
    logic [CW-1:0]       ones_q, ones_d;
    logic [BITDEPTH-1:0] pcm_q, pcm_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(pwm_in),
        .q_o(pwm_s)
    );

    assign sc_rise = sample_clock & ~sc_q;
    assign pwm_ext = CW'(pwm_s);

    // Window FSM: count while capturing, close and restart on each rising edge.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ones_d  = ones_q;
        pcm_d   = pcm_q;
        valid_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            WAIT: begin
                if (sc_rise) begin
                    state_d = CAPTURE;
                    len_d   = CW'(1);
                    ones_d  = pwm_ext;
                end
            end
            CAPTURE: begin
                if (sc_rise) begin
                    valid_d = 1'b1;
                    if (ones_q[SAMPLECLOCK_DIV]) begin
                        pcm_d = '1;
                    end else begin
                        pcm_d = BITDEPTH'(ones_q) << SHIFT;
                    end
                    if (len_q != NOMINAL) begin
                        err_d = 1'b1;
                    end
                    // The closing cycle already belongs to the new window.
                    len_d  = CW'(1);
                    ones_d = pwm_ext;
                end else begin
                    if (len_q != LEN_MAX) begin
                        len_d = len_q + CW'(1);
                    end
                    if (ones_q != NOMINAL) begin
                        ones_d = ones_q + pwm_ext;
                    end
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // Register FSM, counters, edge detector and outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sc_q    <= 1'b0;
            state_q <= WAIT;
            len_q   <= '0;
            ones_q  <= '0;
            pcm_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sc_q    <= sample_clock;
            state_q <= state_d;
            len_q   <= len_d;
            ones_q  <= ones_d;
            pcm_q   <= pcm_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign pcm        = pcm_q;
    assign pcm_valid  = valid_q;
    assign window_err = err_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: directed windows push
// expected samples, a monitor pops them on each pcm_valid.
module tb_pwm_capture;

    typedef struct packed {
        logic [13:0] pcm;
        logic        err;
        logic        tol;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_clock;
    logic        pwm_in;
    logic [13:0] pcm;
    logic        pcm_valid;
    logic        window_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic        use_dac = 1'b0;
    logic [13:0] dac_acc = '0;

    always #5 clk = ~clk;

    pwm_capture #(
        .BITDEPTH(14),
        .SAMPLECLOCK_DIV(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_clock(sample_clock),
        .pwm_in(pwm_in),
        .pcm(pcm),
        .pcm_valid(pcm_valid),
        .window_err(window_err)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected sample.
    always @(negedge clk) begin
        exp_t e;
        if (pcm_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: pcm %0d, expected no valid", pcm);
            end else begin
                e = sb.pop_front();
                if (e.tol) begin
                    checks++;
                    if (int'(pcm) < int'(e.pcm) - 64 || int'(pcm) > int'(e.pcm) + 64) begin
                        errors++;
                        $display("FAIL loopback_pcm: got %0d, expected %0d +/- 64", pcm, e.pcm);
                    end
                end else begin
                    check("pcm", int'(pcm), int'(e.pcm));
                end
                check("window_err", int'(window_err), int'(e.err));
            end
        end
    end

    // One sample_clock window. pwm_in leads by 2 cycles so that
    // pwm_s is high for the first nh cycles of the window.
    task automatic run_window(input int len, input int nh, input int next_nh,
                              input bit push, input int exp_pcm, input bit exp_err,
                              input bit tol, input int rst_at);
        exp_t e;
        if (push) begin
            e.pcm = 14'(exp_pcm);
            e.err = exp_err;
            e.tol = tol;
            sb.push_back(e);
        end
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            sample_clock = (c < len / 2);
            if (use_dac) begin
                {pwm_in, dac_acc} = {1'b0, dac_acc} + 15'd4096;
            end else if (c + 2 < len) begin
                pwm_in = (c + 2 < nh);
            end else begin
                pwm_in = (c + 2 - len < next_nh);
            end
            rst = !(rst_at >= 0 && c >= rst_at && c < rst_at + 3);
            if (rst_at >= 0 && c == len - 1) begin
                check("pcm_held_after_reset", int'(pcm), 0);
            end
        end
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        sample_clock = 1'b0;
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    int lens[13] = '{256, 256, 256, 256, 256, 256, 256, 256, 256, 300, 256, 256, 256};
    int nhs[13]  = '{0, 0, 256, 256, 128, 1, 255, 0, 128, 300, 0, 128, 0};
    int exps[13] = '{0, 0, 16383, 16383, 8192, 64, 16320, 0, 8192, 16383, 0, 8192, 0};
    int errs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    int push[13] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int rsts[13] = '{-1, -1, -1, -1, -1, -1, -1, 160, -1, -1, -1, -1, -1};

    initial begin
        rst = 1'b0;
        sample_clock = 1'b0;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_pcm", int'(pcm), 0);
        check("reset_valid", int'(pcm_valid), 0);
        check("reset_err", int'(window_err), 0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_window(lens[i], nhs[i], (i < 12) ? nhs[i + 1] : 0,
                       push[i] != 0, exps[i], errs[i] != 0, 1'b0, rsts[i]);
        end
        drain("directed_drain");
        check("err_sticky", int'(window_err), 1);

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("err_cleared", int'(window_err), 0);
        check("pcm_cleared", int'(pcm), 0);
        rst = 1'b1;

        use_dac = 1'b1;
        dac_acc = '0;
        for (int i = 0; i < 5; i++) begin
            run_window(256, 0, 0, i < 4, 4096, 1'b0, 1'b1, -1);
        end
        use_dac = 1'b0;
        drain("loopback_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
